// File: rtl/mc_run_sequencer.sv
// Monte Carlo run sequencer: launches num paths, accumulates their prices and divides for the mean.
// Optional per-path watchdog is compiled in when MC_TIMEOUT_EN is defined.
module mc_run_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] num,
  output logic       busy,
  output logic       path_start,
  output logic [7:0] path_idx,
  input  logic       path_done,
  input  logic [7:0] path_price,
  output logic [7:0] P,
  output logic       valid,
  output logic       err
);

  localparam int unsigned NW        = 8;
  localparam int unsigned SW        = 16;
  localparam int unsigned DIV_STEPS = 16;
  localparam int unsigned STEP_W    = $clog2(DIV_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NW-1:0]     r_num;
  logic [NW-1:0]     r_count;
  logic [SW-1:0]     r_sum;
  logic [NW-1:0]     r_rem;
  logic [STEP_W-1:0] r_step;

  logic              w_accept;
  logic              w_done_acc;
  logic [NW-1:0]     w_count_inc;
  logic [NW:0]       w_trial;
  logic              w_ge;
  logic [NW-1:0]     w_rem_nxt;

`ifdef MC_TIMEOUT_EN
  logic [15:0]       r_wd;
  logic              w_wd_expired;
  logic              w_timeout;

  assign w_wd_expired = (r_wd == 16'(TIMEOUT_CYC - 1));
`endif

  assign w_count_inc = r_count + NW'(1);

  // Restoring division step; r_sum doubles as the dividend/quotient shift register.
  assign w_trial   = {r_rem, r_sum[SW-1]};
  assign w_ge      = (w_trial >= {1'b0, r_num});
  assign w_rem_nxt = w_ge ? NW'(w_trial - {1'b0, r_num}) : w_trial[NW-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_acc  = 1'b0;
`ifdef MC_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_state_nxt = (num == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: w_state_nxt = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (path_done) begin
          w_done_acc  = 1'b1;
          w_state_nxt = (w_count_inc < r_num) ? S_LAUNCH : S_DIVIDE;
        end
`ifdef MC_TIMEOUT_EN
        else if (w_wd_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DIVIDE: begin
        if (abort)                                   w_state_nxt = S_IDLE;
        else if (r_step == STEP_W'(DIV_STEPS - 1))   w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulator and divider datapath; each update is qualified by a distinct state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num   <= '0;
      r_count <= '0;
      r_sum   <= '0;
      r_rem   <= '0;
      r_step  <= '0;
    end else begin
      if (w_accept) begin
        r_num   <= num;
        r_count <= '0;
        r_sum   <= '0;
        r_rem   <= '0;
        r_step  <= '0;
      end
      if (w_done_acc) begin
        r_sum   <= r_sum + SW'(path_price);
        r_count <= w_count_inc;
      end
      if (r_state == S_DIVIDE && !abort) begin
        r_sum  <= {r_sum[SW-2:0], w_ge};
        r_rem  <= w_rem_nxt;
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      path_start <= 1'b0;
      path_idx   <= '0;
      valid      <= 1'b0;
      P          <= '0;
    end else begin
      busy       <= (w_state_nxt != S_IDLE);
      path_start <= (w_state_nxt == S_LAUNCH);
      valid      <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_LAUNCH)
        path_idx <= (r_state == S_IDLE) ? '0 : w_count_inc;
      // A timeout entry into DONE leaves P untouched.
      if (w_state_nxt == S_DONE) begin
        if (r_state == S_IDLE)        P <= '0;
        else if (r_state == S_DIVIDE) P <= {r_sum[NW-2:0], w_ge};
      end
    end
  end

`ifdef MC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                   r_wd <= '0;
    else if (r_state != S_WAIT) r_wd <= '0;
    else                       r_wd <= r_wd + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)            err <= 1'b0;
    else if (w_accept)  err <= 1'b0;
    else if (w_timeout) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mc_run_sequencer.sv
// Self-checking bench for mc_run_sequencer: vector table plus hand-written abort/reset/noise sequences.
module tb_mc_run_sequencer;

  localparam int unsigned TO_CYC = 20;

  logic       clk = 1'b0;
  logic       rst, start, abort, path_done;
  logic [7:0] num, path_price, path_idx, P;
  logic       busy, path_start, valid, err;

  always #5 clk = ~clk;

  mc_run_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num(num),
    .busy(busy), .path_start(path_start), .path_idx(path_idx),
    .path_done(path_done), .path_price(path_price),
    .P(P), .valid(valid), .err(err)
  );

  typedef struct {
    logic [7:0]       num;
    logic [3:0][7:0]  pr;
    logic [7:0]       fill;
    int               dly;
    bit               noise;
    logic [7:0]       exp_p;
  } vec_t;

  typedef struct {
    logic [7:0] p;
    logic       e;
  } exp_t;

  exp_t       exp_q[$];
  vec_t       vecs[8];
  int         errors = 0, checks = 0, cyc = 0;
  int         n_launch = 0, n_valid = 0, n_push = 0;
  logic [7:0] p_hold = 8'd0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every valid pulse must match the oldest expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (path_start) n_launch++;
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("P", int'(P), int'(e.p));
        chk("err", int'(err), int'(e.e));
        p_hold = e.p;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation did not finish");
  end

  function automatic logic [7:0] price_of(input vec_t v, input int i);
    return (i < 4) ? v.pr[i] : v.fill;
  endfunction

  // Called on a negedge; returns on a negedge.
  task automatic run_vec(input vec_t v, input string tag);
    int   k, n0, budget;
    exp_t e;
    n0    = n_launch;
    e.p   = v.exp_p;
    e.e   = 1'b0;
    exp_q.push_back(e);
    n_push++;
    num   = v.num;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k     = cyc;
    if (v.num == 8'd0) begin
      chk({tag, "_zero_valid"}, int'(valid), 1);
    end else begin
      chk({tag, "_first_launch"}, int'(path_start), 1);
      for (int i = 0; i < int'(v.num); i++) begin
        budget = 0;
        while (!path_start && budget < 100) begin
          @(negedge clk);
          budget++;
        end
        if (!path_start) begin
          chk({tag, "_launch_timeout"}, 0, 1);
          return;
        end
        if (i < 4 || i == int'(v.num) - 1) chk({tag, "_idx"}, int'(path_idx), i);
        if (v.noise) begin
          path_done  = 1'b1;
          path_price = 8'd200;
          start      = 1'b1;
          num        = 8'd7;
        end
        @(negedge clk);
        path_done = 1'b0;
        start     = 1'b0;
        num       = v.num;
        repeat (v.dly - 1) @(negedge clk);
        path_done  = 1'b1;
        path_price = price_of(v, i);
        k          = cyc;
        @(negedge clk);
        path_done = 1'b0;
      end
      if (v.noise) begin
        repeat (2) @(negedge clk);
        path_done  = 1'b1;
        path_price = 8'd255;
        start      = 1'b1;
        num        = 8'd0;
        repeat (3) @(negedge clk);
        path_done = 1'b0;
        start     = 1'b0;
        num       = v.num;
      end
      budget = 0;
      while (!valid && budget < 40) begin
        @(negedge clk);
        budget++;
      end
      chk({tag, "_valid_latency"}, cyc - k, 17);
    end
    @(negedge clk);
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_launches"}, n_launch - n0, int'(v.num));
  endtask

  initial begin
    int   budget, l0;
    exp_t e;
    rst = 1'b1; start = 1'b0; abort = 1'b0; path_done = 1'b0;
    num = 8'd0; path_price = 8'd0;

    vecs[0] = '{8'd4,   {8'd32, 8'd24, 8'd16, 8'd8},     8'd0,   3, 1'b0, 8'd20};
    vecs[1] = '{8'd0,   {8'd0, 8'd0, 8'd0, 8'd0},        8'd0,   1, 1'b0, 8'd0};
    vecs[2] = '{8'd3,   {8'd0, 8'd2, 8'd1, 8'd1},        8'd0,   1, 1'b0, 8'd1};
    vecs[3] = '{8'd255, {8'd255, 8'd255, 8'd255, 8'd255}, 8'd255, 1, 1'b0, 8'd255};
    vecs[4] = '{8'd1,   {8'd0, 8'd0, 8'd0, 8'd200},      8'd0,   4, 1'b0, 8'd200};
    vecs[5] = '{8'd5,   {8'd40, 8'd30, 8'd20, 8'd10},    8'd50,  2, 1'b1, 8'd30};
    vecs[6] = '{8'd2,   {8'd0, 8'd0, 8'd4, 8'd3},        8'd0,   1, 1'b0, 8'd3};
    vecs[7] = '{8'd6,   {8'd9, 8'd7, 8'd0, 8'd255},      8'd1,   2, 1'b0, 8'd45};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_path_start", int'(path_start), 0);
    chk("rst_path_idx", int'(path_idx), 0);
    chk("rst_P", int'(P), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort held in IDLE blocks start
    start = 1'b1; abort = 1'b1; num = 8'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_launch", int'(path_start), 0);

    // abort in the second WAIT, coinciding with path_done
    num = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_launch0", int'(path_start), 1);
    @(negedge clk);
    path_done = 1'b1; path_price = 8'd50;
    @(negedge clk);
    path_done = 1'b0;
    chk("abort_launch1", int'(path_start), 1);
    chk("abort_idx1", int'(path_idx), 1);
    @(negedge clk);
    abort = 1'b1; path_done = 1'b1; path_price = 8'd99;
    @(negedge clk);
    abort = 1'b0; path_done = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_P_hold", int'(P), 45);
    repeat (3) @(negedge clk);
    chk("abort_idle_launch", int'(path_start), 0);
    chk("abort_P_hold2", int'(P), int'(p_hold));
    run_vec(vecs[6], "after_abort");

`ifdef MC_TIMEOUT_EN
    // first path never completes: timeout reaches DONE with err set and P unchanged
    e.p = p_hold; e.e = 1'b1;
    exp_q.push_back(e);
    n_push++;
    num = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l0 = cyc;
    budget = 0;
    while (!valid && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    chk("to_latency", cyc - (l0 + 1), TO_CYC);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", int'(err), 1);
    chk("to_busy", int'(busy), 0);
    run_vec(vecs[2], "after_timeout");
`endif

    // reset mid-run drops the run and clears every output
    num = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    path_done = 1'b1; path_price = 8'd77;
    @(negedge clk);
    path_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_path_start", int'(path_start), 0);
    chk("midrst_path_idx", int'(path_idx), 0);
    chk("midrst_P", int'(P), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_err", int'(err), 0);
    rst = 1'b0;
    p_hold = 8'd0;
    repeat (2) @(negedge clk);
    chk("midrst_idle", int'(busy), 0);
    run_vec(vecs[0], "after_rst");

    repeat (5) @(negedge clk);
    chk("valid_count", n_valid, n_push);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
